// File: rtl/core_mem_responder.sv
// core_mem_responder: word RAM plus MMIO console FIFO, STATUS, EXIT and optional TIMER (CORE_MEM_TIMER_EN)
module core_mem_responder #(
  parameter int          MEM_WORDS  = 4096,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halted,
  output logic [31:0] exit_code,
  output logic        bad_access
);
  localparam int ADDR_W = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [31:0] ram [MEM_WORDS];
  logic [7:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic overflow, full, empty, ram_hit, mmio_hit, wr, push, push_ok, pop;
  logic [1:0] sel;
  logic [31:0] status, timer_rd, mmio_rd;
  assign ram_hit = (address >> (ADDR_W + 2)) == 32'd0;
  assign mmio_hit = address[31:4] == MMIO_BASE[31:4];
  assign sel = address[3:2];
  assign wr = we && !halted;
  assign full = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign pop = tx_valid && tx_ready;
  assign push = wr && mmio_hit && sel == 2'd0;
  assign push_ok = push && (!full || pop);
  assign tx_valid = !empty;
  assign tx_data = fifo[rd_ptr];
  assign status = {16'd0, 8'(count), 5'd0, overflow, empty, full};
  assign mmio_rd = sel == 2'd0 ? 32'd0 : sel == 2'd1 ? status : sel == 2'd2 ? exit_code : timer_rd;
  assign rdata = ram_hit ? ram[address[ADDR_W+1:2]] : mmio_hit ? mmio_rd : 32'd0;
  always_ff @(posedge clk) begin
    if (wr && ram_hit) ram[address[ADDR_W+1:2]] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_ptr] <= wdata[7:0];
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      halted <= 1'b0;
      exit_code <= '0;
      bad_access <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push_ok);
      count <= count + CW'(push_ok) - CW'(pop);
      overflow <= overflow || (push && !push_ok);
      bad_access <= wr && !ram_hit && !mmio_hit;
      if (wr && mmio_hit && sel == 2'd2) begin
        halted <= 1'b1;
        exit_code <= wdata;
      end
    end
  end
`ifdef CORE_MEM_TIMER_EN
  logic [31:0] timer;
  always_ff @(posedge clk) begin
    if (!resetn) timer <= '0;
    else if (wr && mmio_hit && sel == 2'd3) timer <= wdata;
    else if (!halted) timer <= timer + 32'd1;
  end
  assign timer_rd = timer;
`else
  assign timer_rd = 32'd0;
`endif
endmodule

// File: tb/tb_core_mem_responder.sv
// tb_core_mem_responder: directed vectors, corner sequences and randomized traffic against a queue-based model
module tb_core_mem_responder;
  localparam int DEPTH = 16;
  localparam logic [31:0] TXD = 32'hFFFF_FF00, STA = 32'hFFFF_FF04, EXT = 32'hFFFF_FF08, TMR = 32'hFFFF_FF0C;
  logic clk = 1'b0, resetn = 1'b0, we = 1'b0, tx_ready = 1'b0;
  logic [31:0] address = '0, wdata = '0;
  logic [31:0] rdata, exit_code;
  logic [7:0] tx_data;
  logic tx_valid, halted, bad_access;
  int n_chk = 0, n_fail = 0;

  core_mem_responder dut (
    .clk(clk), .resetn(resetn), .address(address), .wdata(wdata), .we(we), .rdata(rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .halted(halted),
    .exit_code(exit_code), .bad_access(bad_access)
  );

  always #5 clk = ~clk;

  logic [31:0] mram [int unsigned];
  logic [7:0] q[$];
  bit m_ovf, m_halt, m_bad;
  logic [31:0] m_exit, m_timer;

  function automatic logic [31:0] m_status();
    return {16'd0, 8'(q.size()), 5'd0, m_ovf, q.size() == 0, q.size() == DEPTH};
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a, output bit known);
    known = 1'b1;
    if ((a >> 14) == 0) begin
      known = mram.exists(a >> 2);
      return known ? mram[a >> 2] : 32'd0;
    end
    if (a[31:4] != 28'hFFFF_FF0) return 32'd0;
    if (a[3:2] == 2'd1) return m_status();
    if (a[3:2] == 2'd2) return m_exit;
`ifdef CORE_MEM_TIMER_EN
    if (a[3:2] == 2'd3) return m_timer;
`endif
    return 32'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic set(input logic [31:0] a, input logic [31:0] w, input logic e, input logic r);
    address = a;
    wdata = w;
    we = e;
    tx_ready = r;
    #1;
  endtask

  task automatic step();
    bit pop, acc, wr;
    logic [31:0] tn;
    @(posedge clk);
    if (!resetn) begin
      q.delete();
      m_ovf = 0; m_halt = 0; m_bad = 0; m_exit = '0; m_timer = '0;
    end else begin
      pop = q.size() != 0 && tx_ready;
      acc = q.size() < DEPTH || pop;
      wr = we && !m_halt;
      tn = m_halt ? m_timer : m_timer + 32'd1;
      m_bad = 0;
      if (pop) void'(q.pop_front());
      if (wr) begin
        if ((address >> 14) == 0) mram[address >> 2] = wdata;
        else if (address[31:4] == 28'hFFFF_FF0) begin
          if (address[3:2] == 2'd0) begin
            if (acc) q.push_back(wdata[7:0]);
            else m_ovf = 1;
          end else if (address[3:2] == 2'd2) begin
            m_halt = 1;
            m_exit = wdata;
          end else if (address[3:2] == 2'd3) tn = wdata;
        end else m_bad = 1;
      end
      m_timer = tn;
    end
    #1;
  endtask

  task automatic check_model();
    bit k;
    logic [31:0] e;
    e = m_rd(address, k);
    if (k) chk("model rdata", rdata, e);
    chk("model tx_valid", {31'd0, tx_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) chk("model tx_data", {24'd0, tx_data}, {24'd0, q[0]});
    chk("model bad_access", {31'd0, bad_access}, {31'd0, m_bad});
    chk("model halted", {31'd0, halted}, {31'd0, m_halt});
    chk("model exit_code", exit_code, m_exit);
  endtask

  task automatic rand_cycle(input int i);
    logic [31:0] a;
    logic e, r;
    e = 1'($urandom_range(0, 1));
    r = ((i / 50) % 2) != 0 ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
    case ($urandom_range(0, 11))
      0, 1, 2, 3: a = 32'($urandom_range(0, 255));
      4: a = 32'h3FFC + 32'($urandom_range(0, 3));
      5, 6, 7: a = TXD + 32'($urandom_range(0, 3));
      8: a = STA;
      9: a = TMR;
      10: begin a = EXT; e = 1'b0; end
      default: case ($urandom_range(0, 3))
        0: a = 32'h0000_4000;
        1: a = 32'hFFFF_FEFC;
        2: a = 32'hFFFF_FF10;
        default: a = 32'h8000_0000 | $urandom;
      endcase
    endcase
    set(a, $urandom, e, r);
    check_model();
    step();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    set(STA, 0, 0, 0);
    step();
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [31:0] a, w;
    logic we, rdy, cr;
    logic [31:0] er;
    logic ev;
    logic [7:0] ed;
  } vec_t;
  vec_t tv[15];
  logic [7:0] drain_exp[16];

  initial begin
    tv[0]  = '{32'h100, 32'hDEADBEEF, 1, 0, 0, 32'h0, 0, 8'h00};
    tv[1]  = '{32'h100, 32'h0, 0, 0, 1, 32'hDEADBEEF, 0, 8'h00};
    tv[2]  = '{32'h103, 32'h0, 0, 0, 1, 32'hDEADBEEF, 0, 8'h00};
    tv[3]  = '{STA, 32'h0, 0, 0, 1, 32'h2, 0, 8'h00};
    tv[4]  = '{TXD, 32'h48, 1, 0, 1, 32'h0, 0, 8'h00};
    tv[5]  = '{TXD, 32'h69, 1, 0, 1, 32'h0, 1, 8'h48};
    tv[6]  = '{STA, 32'h0, 0, 0, 1, 32'h200, 1, 8'h48};
    tv[7]  = '{STA, 32'h0, 0, 1, 1, 32'h200, 1, 8'h48};
    tv[8]  = '{STA, 32'h0, 0, 1, 1, 32'h100, 1, 8'h69};
    tv[9]  = '{STA, 32'h0, 0, 0, 1, 32'h2, 0, 8'h00};
    tv[10] = '{EXT, 32'h0, 0, 0, 1, 32'h0, 0, 8'h00};
    tv[11] = '{32'h8000_0000, 32'h0, 0, 0, 1, 32'h0, 0, 8'h00};
    tv[12] = '{32'h4000, 32'h0, 0, 0, 1, 32'h0, 0, 8'h00};
    tv[13] = '{32'h3FFC, 32'hCAFEF00D, 1, 0, 0, 32'h0, 0, 8'h00};
    tv[14] = '{32'h3FFF, 32'h0, 0, 0, 1, 32'hCAFEF00D, 0, 8'h00};

    set(STA, 0, 0, 0);
    step();
    step();
    resetn = 1'b1;
    set(STA, 0, 0, 0);
    chk("reset status", rdata, 32'h2);
    chk("reset tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("reset halted", {31'd0, halted}, 32'd0);
    chk("reset exit_code", exit_code, 32'd0);
    chk("reset bad_access", {31'd0, bad_access}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      set(tv[i].a, tv[i].w, tv[i].we, tv[i].rdy);
      if (tv[i].cr) chk($sformatf("vec%0d rdata", i), rdata, tv[i].er);
      chk($sformatf("vec%0d tx_valid", i), {31'd0, tx_valid}, {31'd0, tv[i].ev});
      if (tv[i].ev) chk($sformatf("vec%0d tx_data", i), {24'd0, tx_data}, {24'd0, tv[i].ed});
      step();
    end

    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      set(TXD, 32'(i), 1, 0);
      step();
    end
    set(STA, 0, 0, 0);
    chk("ovf status", rdata, 32'h1005);
    chk("ovf head", {24'd0, tx_data}, 32'h0);
    set(TXD, 32'hAA, 1, 1);
    step();
    set(STA, 0, 0, 0);
    chk("full push+pop status", rdata, 32'h1005);
    chk("full push+pop head", {24'd0, tx_data}, 32'h1);
    for (int k = 0; k < 15; k++) drain_exp[k] = 8'(k + 1);
    drain_exp[15] = 8'hAA;
    for (int k = 0; k < 16; k++) begin
      set(STA, 0, 0, 1);
      chk($sformatf("drain%0d valid", k), {31'd0, tx_valid}, 32'd1);
      chk($sformatf("drain%0d data", k), {24'd0, tx_data}, {24'd0, drain_exp[k]});
      step();
    end
    set(STA, 0, 0, 0);
    chk("drained valid", {31'd0, tx_valid}, 32'd0);
    chk("drained status", rdata, 32'h6);

    set(32'h8000_0000, 32'h1234, 1, 0);
    chk("bad rdata", rdata, 32'h0);
    chk("bad before", {31'd0, bad_access}, 32'd0);
    step();
    chk("bad pulse", {31'd0, bad_access}, 32'd1);
    set(STA, 0, 0, 0);
    step();
    chk("bad one cycle", {31'd0, bad_access}, 32'd0);
    set(32'hFFFF_FEFC, 32'h1, 1, 0);
    step();
    chk("bad below mmio", {31'd0, bad_access}, 32'd1);

    do_reset();
    set(32'h100, 0, 0, 0);
    chk("ram after reset", rdata, 32'hDEADBEEF);
    for (int i = 0; i < 6; i++) begin
      set(TXD, 32'h30 + 32'(i), 1, 0);
      step();
    end
    set(STA, 0, 0, 1);
    chk("pre drain status", rdata, 32'h600);
    step();
    resetn = 1'b0;
    set(STA, 0, 0, 1);
    chk("mid drain status", rdata, 32'h500);
    chk("mid drain data", {24'd0, tx_data}, 32'h31);
    step();
    resetn = 1'b1;
    set(32'h100, 0, 0, 0);
    chk("drain reset valid", {31'd0, tx_valid}, 32'd0);
    chk("drain reset halted", {31'd0, halted}, 32'd0);
    chk("drain reset ram", rdata, 32'hDEADBEEF);
    set(STA, 0, 0, 0);
    chk("drain reset status", rdata, 32'h2);

`ifdef CORE_MEM_TIMER_EN
    set(TMR, 32'hFFFF_FFFE, 1, 0);
    step();
    set(TMR, 0, 0, 0);
    chk("timer load", rdata, 32'hFFFF_FFFE);
    step();
    chk("timer +1", rdata, 32'hFFFF_FFFF);
    step();
    chk("timer wrap", rdata, 32'h0);
`else
    set(TMR, 32'hFFFF_FFFE, 1, 0);
    step();
    chk("timer write no bad", {31'd0, bad_access}, 32'd0);
    set(TMR, 0, 0, 0);
    chk("timer reads 0", rdata, 32'h0);
    step();
    chk("timer still 0", rdata, 32'h0);
`endif

    for (int i = 0; i < 800; i++) rand_cycle(i);

    set(EXT, 32'h2A, 1, 0);
    step();
    chk("exit halted", {31'd0, halted}, 32'd1);
    chk("exit code", exit_code, 32'd42);
    set(EXT, 0, 0, 0);
    chk("exit read", rdata, 32'd42);
    set(32'h100, 32'h1234_5678, 1, 0);
    step();
    set(32'h100, 0, 0, 0);
    chk("halted ram write ignored", rdata, 32'hDEADBEEF);
    set(32'h8000_0000, 32'h1, 1, 0);
    step();
    chk("halted no bad", {31'd0, bad_access}, 32'd0);
    for (int i = 0; i < 40; i++) rand_cycle(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
